// File: rtl/ray_tracer_seq.sv
// ray_tracer_seq
//   Sequential nearest-hit ray tracer. One ray is accepted per valid/ready
//   transaction, then NUM_OBJ object slots are tested one at a time through an
//   external intersection unit (obj_req / t_valid). The nearest hit is kept
//   and, once the last slot answers, a shaded 4-4-4 RGB pixel, the winning id,
//   its distance and a collision flag are presented on the result port.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ray_valid/ray_ready ray handshake; ray_ready is high only while idle
//   ray_init, ray_dir   packed ray origin / direction
//   obj_req             one-cycle request strobe to the intersection unit
//   obj_id              object slot under test
//   obj_init, obj_dir   latched ray, stable for the whole scan
//   t_valid, t_hit, t_in intersection response (t_in meaningful when t_hit)
//   res_valid/res_ready result handshake
//   res_color           shaded pixel colour
//   res_obj_id, res_t   nearest object id and distance (all ones if no hit)
//   res_hit             at least one object was hit
//   collision_sig       nearest hit lies within COLLISION_BOUND
module ray_tracer_seq #(
  parameter int NUM_OBJ         = 8,
  parameter int T_W             = 10,
  parameter int COORD_W         = 28,
  parameter int COLLISION_BOUND = 2,
  parameter int TRACING_BOUND   = 200,
  parameter int SHADE_MODE      = 0,
  localparam int ID_W           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ray_valid,
  output logic               ray_ready,
  input  logic [COORD_W-1:0] ray_init,
  input  logic [COORD_W-1:0] ray_dir,
  output logic               obj_req,
  output logic [ID_W-1:0]    obj_id,
  output logic [COORD_W-1:0] obj_init,
  output logic [COORD_W-1:0] obj_dir,
  input  logic               t_valid,
  input  logic               t_hit,
  input  logic [T_W-1:0]     t_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [11:0]        res_color,
  output logic [ID_W-1:0]    res_obj_id,
  output logic [T_W-1:0]     res_t,
  output logic               res_hit,
  output logic               collision_sig
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_OBJ - 1);
  localparam logic [T_W-1:0]  TB_T    = T_W'(TRACING_BOUND);
  localparam logic [T_W-1:0]  CB_T    = T_W'(COLLISION_BOUND);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [T_W-1:0]  best_t_q, best_t_n;
  logic            best_hit_q, best_hit_n;
  logic [ID_W-1:0] best_id_q, best_id_n;

  logic load_ray;
  logic take_resp;
  logic scan_last;

  // Depth shading. Hits beyond the tracing bound, and misses, are background.
  // The grey ramp maps t=0 to full white and t=TRACING_BOUND to black.
  function automatic logic [11:0] shade(input logic hit, input logic [T_W-1:0] t);
    logic [T_W+3:0] prod;
    logic [3:0]     lvl;
    prod = '0;
    lvl  = '0;
    if (!hit || (t > TB_T)) begin
      shade = 12'h000;
    end else if (SHADE_MODE == 0) begin
      shade = 12'hFFF;
    end else begin
      prod  = (T_W+4)'(TB_T - t) * (T_W+4)'(15);
      lvl   = 4'(prod / (T_W+4)'(TRACING_BOUND));
      shade = {lvl, lvl, lvl};
    end
  endfunction

  function automatic logic collide(input logic hit, input logic [T_W-1:0] t);
    collide = hit && (t <= CB_T);
  endfunction

  assign ray_ready = (state_q == IDLE);
  assign obj_req   = (state_q == ISSUE);
  assign res_valid = (state_q == DONE);
  assign scan_last = (obj_id == LAST_ID);

  // Next-state and scan control
  always_comb begin
    state_d   = state_q;
    load_ray  = 1'b0;
    take_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (ray_valid) begin
          load_ray = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Responses are only consumed here; strobes in any other state are dropped.
        if (t_valid) begin
          take_resp = 1'b1;
          state_d   = scan_last ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Running nearest hit. Strict compare keeps the lowest id on equal t.
  always_comb begin
    best_t_n   = best_t_q;
    best_hit_n = best_hit_q;
    best_id_n  = best_id_q;
    if (take_resp && t_hit && (t_in < best_t_q)) begin
      best_t_n   = t_in;
      best_hit_n = 1'b1;
      best_id_n  = obj_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      obj_id        <= '0;
      obj_init      <= '0;
      obj_dir       <= '0;
      best_t_q      <= '1;
      best_hit_q    <= 1'b0;
      best_id_q     <= '0;
      res_color     <= 12'h000;
      res_obj_id    <= '0;
      res_t         <= '1;
      res_hit       <= 1'b0;
      collision_sig <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load_ray) begin
        obj_init   <= ray_init;
        obj_dir    <= ray_dir;
        obj_id     <= '0;
        best_t_q   <= '1;
        best_hit_q <= 1'b0;
        best_id_q  <= '0;
      end else if (take_resp) begin
        best_t_q   <= best_t_n;
        best_hit_q <= best_hit_n;
        best_id_q  <= best_id_n;
        if (!scan_last) begin
          obj_id <= obj_id + ID_W'(1);
        end
      end

      // Result is captured from the post-update best on the way into DONE,
      // so the last response is already folded in; it then holds until the
      // next ray completes.
      if (take_resp && scan_last) begin
        res_hit       <= best_hit_n;
        res_t         <= best_t_n;
        res_obj_id    <= best_id_n;
        res_color     <= shade(best_hit_n, best_t_n);
        collision_sig <= collide(best_hit_n, best_t_n);
      end
    end
  end

endmodule

// File: tb/tb_ray_tracer_seq.sv
// Bench for ray_tracer_seq: two instances (binary and grey shading) share all
// inputs; scenes are played back through a behavioural intersection unit and
// results are compared against a reference built from the scene table.
module tb_ray_tracer_seq;

  localparam int NUM_OBJ = 8;
  localparam int T_W     = 10;
  localparam int COORD_W = 28;
  localparam int ID_W    = 3;

  typedef struct packed {
    logic            hit;
    logic [T_W-1:0]  t;
    logic [ID_W-1:0] id;
    logic [11:0]     c0;
    logic [11:0]     c1;
    logic            coll;
  } result_s;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               ray_valid, res_ready, t_valid, t_hit;
  logic [COORD_W-1:0] ray_init, ray_dir;
  logic [T_W-1:0]     t_in;

  logic               ray_ready, obj_req, res_valid, res_hit, collision_sig;
  logic [ID_W-1:0]    obj_id, res_obj_id;
  logic [COORD_W-1:0] obj_init, obj_dir;
  logic [11:0]        res_color;
  logic [T_W-1:0]     res_t;

  logic               g_ray_ready, g_obj_req, g_res_valid, g_res_hit, g_collision_sig;
  logic [ID_W-1:0]    g_obj_id, g_res_obj_id;
  logic [COORD_W-1:0] g_obj_init, g_obj_dir;
  logic [11:0]        g_res_color;
  logic [T_W-1:0]     g_res_t;

  ray_tracer_seq #(.NUM_OBJ(NUM_OBJ), .T_W(T_W), .COORD_W(COORD_W), .COLLISION_BOUND(2),
                   .TRACING_BOUND(200), .SHADE_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_init(ray_init), .ray_dir(ray_dir), .obj_req(obj_req), .obj_id(obj_id),
    .obj_init(obj_init), .obj_dir(obj_dir), .t_valid(t_valid), .t_hit(t_hit),
    .t_in(t_in), .res_valid(res_valid), .res_ready(res_ready), .res_color(res_color),
    .res_obj_id(res_obj_id), .res_t(res_t), .res_hit(res_hit),
    .collision_sig(collision_sig));

  ray_tracer_seq #(.NUM_OBJ(NUM_OBJ), .T_W(T_W), .COORD_W(COORD_W), .COLLISION_BOUND(2),
                   .TRACING_BOUND(200), .SHADE_MODE(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .ray_valid(ray_valid), .ray_ready(g_ray_ready),
    .ray_init(ray_init), .ray_dir(ray_dir), .obj_req(g_obj_req), .obj_id(g_obj_id),
    .obj_init(g_obj_init), .obj_dir(g_obj_dir), .t_valid(t_valid), .t_hit(t_hit),
    .t_in(t_in), .res_valid(g_res_valid), .res_ready(res_ready), .res_color(g_res_color),
    .res_obj_id(g_res_obj_id), .res_t(g_res_t), .res_hit(g_res_hit),
    .collision_sig(g_collision_sig));

  int n_checks = 0;
  int n_fail   = 0;

  // Scene table driven by the behavioural intersection unit
  bit sc_hit  [NUM_OBJ];
  int sc_t    [NUM_OBJ];
  int sc_lat  [NUM_OBJ];
  bit sc_spur [NUM_OBJ];
  logic [COORD_W-1:0] cur_init, cur_dir;

  // Independent request monitor
  int pulse_count = 0;
  int id_q[$];
  always @(negedge clk) begin
    if (rst_n && obj_req) begin
      pulse_count++;
      id_q.push_back(int'(obj_id));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(input result_s r);
    return $sformatf("hit=%b t=%0d id=%0d c0=%h c1=%h coll=%b", r.hit, r.t, r.id, r.c0, r.c1, r.coll);
  endfunction

  // Reference: nearest distance among hit slots, first slot with that
  // distance wins, then colour from the bounds.
  function automatic result_s model_ray();
    result_s r;
    bit any;
    int best, bid, lvl;
    any  = 0;
    best = 1023;
    bid  = 0;
    foreach (sc_hit[i]) if (sc_hit[i]) begin
      any = 1;
      if (sc_t[i] < best) best = sc_t[i];
    end
    for (int i = NUM_OBJ - 1; i >= 0; i--) if (any && sc_hit[i] && sc_t[i] == best) bid = i;
    r.hit  = any;
    r.t    = any ? 10'(best) : 10'h3FF;
    r.id   = 3'(bid);
    r.coll = any && (best <= 2);
    if (any && best <= 200) begin
      lvl  = ((200 - best) * 15) / 200;
      r.c0 = 12'hFFF;
      r.c1 = {4'(lvl), 4'(lvl), 4'(lvl)};
    end else begin
      r.c0 = 12'h000;
      r.c1 = 12'h000;
    end
    return r;
  endfunction

  task automatic clear_scene(input int lat);
    for (int i = 0; i < NUM_OBJ; i++) begin
      sc_hit[i] = 0; sc_t[i] = 0; sc_lat[i] = lat; sc_spur[i] = 0;
    end
  endtask

  task automatic offer_ray();
    int k;
    cur_init  = COORD_W'($urandom);
    cur_dir   = COORD_W'($urandom);
    ray_init  = cur_init;
    ray_dir   = cur_dir;
    ray_valid = 1'b1;
    k = 0;
    while (!ray_ready && k < 40) begin @(negedge clk); k++; end
    if (!ray_ready) begin
      n_checks++; n_fail++;
      $display("FAIL offer_timeout ray_ready=%b required=1", ray_ready);
    end
    @(negedge clk);
    ray_valid = 1'b0;
  endtask

  task automatic do_scan(input int first, input int last);
    int k;
    for (int i = first; i <= last; i++) begin
      k = 0;
      while (!obj_req && k < 40) begin @(negedge clk); k++; end
      n_checks++;
      if (!obj_req) begin
        n_fail++;
        $display("FAIL req_timeout slot=%0d obj_req=%b required=1", i, obj_req);
        return;
      end
      if (obj_id !== 3'(i) || obj_init !== cur_init || obj_dir !== cur_dir) begin
        n_fail++;
        $display("FAIL req_fields obj_id=%0d init=%h dir=%h required id=%0d init=%h dir=%h",
                 obj_id, obj_init, obj_dir, i, cur_init, cur_dir);
      end
      if (sc_spur[i]) begin
        t_valid = 1'b1; t_hit = 1'b1; t_in = '0;
      end
      @(negedge clk);
      t_valid = 1'b0; t_hit = 1'b0;
      n_checks++;
      if (obj_req !== 1'b0) begin
        n_fail++;
        $display("FAIL req_single_cycle obj_req=%b required=0", obj_req);
      end
      repeat (sc_lat[i] - 1) @(negedge clk);
      t_valid = 1'b1;
      t_hit   = sc_hit[i];
      t_in    = sc_hit[i] ? 10'(sc_t[i]) : 10'($urandom);
      @(negedge clk);
      t_valid = 1'b0; t_hit = 1'b0; t_in = '0;
    end
  endtask

  task automatic wait_result(output result_s obs);
    int k;
    k = 0;
    while (!res_valid && k < 40) begin @(negedge clk); k++; end
    if (!res_valid) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout res_valid=%b required=1", res_valid);
    end
    obs = {res_hit, res_t, res_obj_id, res_color, g_res_color, collision_sig};
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_ray(output result_s obs);
    offer_ray();
    do_scan(0, NUM_OBJ - 1);
    wait_result(obs);
    release_result();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ray_ready, obj_req, res_valid, res_hit, collision_sig,
         g_ray_ready, g_obj_req, g_res_valid, g_res_hit, g_collision_sig} !== 10'b10000_10000) begin
      n_fail++;
      $display("FAIL reset_ctl observed=%b required=1000010000",
               {ray_ready, obj_req, res_valid, res_hit, collision_sig,
                g_ray_ready, g_obj_req, g_res_valid, g_res_hit, g_collision_sig});
    end
    n_checks++;
    if ({res_t, g_res_t} !== 20'hFFFFF || {res_color, g_res_color} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_res res_t=%h/%h color=%h/%h required 3ff/3ff 000/000",
               res_t, g_res_t, res_color, g_res_color);
    end
    n_checks++;
    if ({obj_id, res_obj_id, g_obj_id, g_res_obj_id, obj_init, obj_dir, g_obj_init, g_obj_dir} !== '0) begin
      n_fail++;
      $display("FAIL reset_data obj_id=%0d res_obj_id=%0d obj_init=%h obj_dir=%h required all 0",
               obj_id, res_obj_id, obj_init, obj_dir);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nearest();
    result_s obs, exp;
    clear_scene(1);
    sc_hit[3] = 1; sc_t[3] = 50;
    sc_hit[6] = 1; sc_t[6] = 30;
    exp = {1'b1, 10'd30, 3'd6, 12'hFFF, 12'hCCC, 1'b0};
    run_ray(obs);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL nearest observed %s required %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_tie_and_miss();
    result_s obs, exp;
    clear_scene(2);
    sc_hit[2] = 1; sc_t[2] = 1;
    sc_hit[5] = 1; sc_t[5] = 1;
    exp = {1'b1, 10'd1, 3'd2, 12'hFFF, 12'hEEE, 1'b1};
    run_ray(obs);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL tie observed %s required %s", fmt(obs), fmt(exp));
    end
    clear_scene(1);
    exp = {1'b0, 10'h3FF, 3'd0, 12'h000, 12'h000, 1'b0};
    run_ray(obs);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL miss observed %s required %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_shading();
    result_s obs, exp;
    int tv  [4] = '{201, 0, 100, 200};
    int idv [4] = '{4, 0, 7, 2};
    result_s ev [4];
    ev[0] = {1'b1, 10'd201, 3'd4, 12'h000, 12'h000, 1'b0};
    ev[1] = {1'b1, 10'd0,   3'd0, 12'hFFF, 12'hFFF, 1'b1};
    ev[2] = {1'b1, 10'd100, 3'd7, 12'hFFF, 12'h777, 1'b0};
    ev[3] = {1'b1, 10'd200, 3'd2, 12'hFFF, 12'h000, 1'b0};
    for (int v = 0; v < 4; v++) begin
      clear_scene(1);
      sc_hit[idv[v]] = 1; sc_t[idv[v]] = tv[v];
      exp = ev[v];
      run_ray(obs);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL shade_t%0d observed %s required %s", tv[v], fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_backpressure();
    result_s obs0, obs, exp;
    bit unstable, busy;
    int p0;
    clear_scene(1);
    sc_hit[1] = 1; sc_t[1] = 7;
    exp = model_ray();
    offer_ray();
    do_scan(0, NUM_OBJ - 1);
    wait_result(obs0);
    n_checks++;
    if (obs0 !== exp) begin
      n_fail++;
      $display("FAIL hold_first observed %s required %s", fmt(obs0), fmt(exp));
    end
    cur_init = COORD_W'($urandom);
    cur_dir  = COORD_W'($urandom);
    ray_init = cur_init; ray_dir = cur_dir; ray_valid = 1'b1;
    p0 = pulse_count;
    unstable = 0; busy = 0;
    for (int c = 0; c < 20; c++) begin
      obs = {res_hit, res_t, res_obj_id, res_color, g_res_color, collision_sig};
      if (obs !== exp || res_valid !== 1'b1) unstable = 1;
      if (ray_ready !== 1'b0) busy = 1;
      @(negedge clk);
    end
    n_checks++;
    if (unstable) begin
      n_fail++;
      $display("FAIL hold_stable observed %s valid=%b required %s valid=1", fmt(obs), res_valid, fmt(exp));
    end
    n_checks++;
    if (busy || pulse_count != p0) begin
      n_fail++;
      $display("FAIL hold_no_accept ray_ready_seen_high=%b obj_req_pulses=%0d required 0 and 0",
               busy, pulse_count - p0);
    end
    release_result();
    n_checks++;
    if (ray_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_idle ray_ready=%b res_valid=%b required 1 0", ray_ready, res_valid);
    end
    @(negedge clk);
    ray_valid = 1'b0;
    n_checks++;
    if (obj_req !== 1'b1 || obj_id !== 3'd0) begin
      n_fail++;
      $display("FAIL next_accept obj_req=%b obj_id=%0d required 1 0", obj_req, obj_id);
    end
    clear_scene(3);
    sc_hit[0] = 1; sc_t[0] = 150;
    sc_hit[4] = 1; sc_t[4] = 120;
    exp = model_ray();
    do_scan(0, NUM_OBJ - 1);
    wait_result(obs);
    release_result();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL after_hold observed %s required %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_latency_spurious();
    result_s obs, exp;
    int p0;
    bit order_bad;
    clear_scene(1);
    for (int i = 0; i < NUM_OBJ; i++) begin
      sc_lat[i]  = (i % 2 == 0) ? 1 : 7;
      sc_spur[i] = 1;
      sc_hit[i]  = (i != 3);
      sc_t[i]    = 40 + 10 * i;
    end
    exp = model_ray();
    // Spurious strobes while idle
    t_valid = 1'b1; t_hit = 1'b1; t_in = '0;
    repeat (2) @(negedge clk);
    t_valid = 1'b0; t_hit = 1'b0;
    p0 = pulse_count;
    id_q.delete();
    run_ray(obs);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL latency_result observed %s required %s", fmt(obs), fmt(exp));
    end
    order_bad = (id_q.size() != NUM_OBJ);
    for (int i = 0; i < id_q.size() && i < NUM_OBJ; i++) if (id_q[i] != i) order_bad = 1;
    n_checks++;
    if (pulse_count - p0 != NUM_OBJ || order_bad) begin
      n_fail++;
      $display("FAIL req_sequence pulses=%0d in_order=%b required pulses=%0d in_order=1",
               pulse_count - p0, !order_bad, NUM_OBJ);
    end
  endtask

  task automatic test_async_reset();
    result_s obs, exp;
    int k;
    bit bad;
    clear_scene(2);
    for (int i = 0; i < NUM_OBJ; i++) begin
      sc_hit[i] = 1; sc_t[i] = 5 + i;
    end
    offer_ray();
    do_scan(0, 3);
    k = 0;
    while (!obj_req && k < 40) begin @(negedge clk); k++; end
    n_checks++;
    if (obj_req !== 1'b1 || obj_id !== 3'd4) begin
      n_fail++;
      $display("FAIL pre_abort obj_req=%b obj_id=%0d required 1 4", obj_req, obj_id);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ray_ready, obj_req, res_valid, res_hit, collision_sig} !== 5'b10000 ||
        res_t !== 10'h3FF || res_color !== 12'h000 || g_res_color !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_outputs ctl=%b res_t=%h color=%h required 10000 3ff 000",
               {ray_ready, obj_req, res_valid, res_hit, collision_sig}, res_t, res_color);
    end
    n_checks++;
    if ({obj_id, res_obj_id, obj_init, obj_dir} !== '0) begin
      n_fail++;
      $display("FAIL abort_data obj_id=%0d res_obj_id=%0d obj_init=%h obj_dir=%h required 0",
               obj_id, res_obj_id, obj_init, obj_dir);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t_valid = 1'b1; t_hit = 1'b1; t_in = 10'd3;
    @(negedge clk);
    t_valid = 1'b0; t_hit = 1'b0;
    bad = 0;
    repeat (4) begin
      if (res_valid !== 1'b0 || obj_req !== 1'b0 || ray_ready !== 1'b1) bad = 1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL late_response res_valid=%b obj_req=%b ray_ready=%b required 0 0 1",
               res_valid, obj_req, ray_ready);
    end
    clear_scene(1);
    sc_hit[5] = 1; sc_t[5] = 60;
    exp = model_ray();
    run_ray(obs);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL post_abort observed %s required %s", fmt(obs), fmt(exp));
    end
  endtask

  task automatic test_random();
    result_s obs, exp;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sc_hit[i]  = ($urandom_range(0, 2) == 0);
        sc_t[i]    = (r % 2 == 0) ? $urandom_range(0, 6) : $urandom_range(0, 400);
        sc_lat[i]  = $urandom_range(1, 4);
        sc_spur[i] = $urandom_range(0, 1);
      end
      exp = model_ray();
      run_ray(obs);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_ray%0d observed %s required %s", r, fmt(obs), fmt(exp));
      end
    end
  endtask

  initial begin
    ray_valid = 1'b0; res_ready = 1'b0; t_valid = 1'b0; t_hit = 1'b0;
    ray_init = '0; ray_dir = '0; t_in = '0;
    cur_init = '0; cur_dir = '0;
    test_reset();
    test_nearest();
    test_tie_and_miss();
    test_shading();
    test_backpressure();
    test_latency_spurious();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
